// File: rtl/alu_exec_unit.sv
// alu_exec_unit: MIPS execute stage with ALU decode, iterative mult/div and HI/LO registers
// Define ALU_DIVIDE_EN to build the restoring divider; otherwise div/divu decode as illegal.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         alu_op,
    input  logic [5:0]         func,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_result,
    output logic               out_zero,
    output logic               out_ovf,
    output logic               out_illegal
);
`ifdef ALU_DIVIDE_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`endif
    state_t state, nxt;
    logic [WIDTH-1:0] hi, lo, acc, qr, mc, sum, dif, res, abs_a, abs_b;
    logic [SHAMT_W-1:0] cnt;
    logic accept, ovf, ill, start_mul, start_div, sgn, neg_lo, add_ovf, sub_ovf, last;
    logic [WIDTH:0] msum;
    logic [2*WIDTH-1:0] prod, fin;
    assign in_ready = state == IDLE;
    assign accept = in_valid & in_ready;
    assign sum = src_a + src_b;
    assign dif = src_a - src_b;
    assign add_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
    assign sub_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (dif[WIDTH-1] != src_a[WIDTH-1]);
    assign abs_a = sgn && src_a[WIDTH-1] ? -src_a : src_a;
    assign abs_b = sgn && src_b[WIDTH-1] ? -src_b : src_b;
    assign last = cnt == SHAMT_W'(WIDTH - 1);
    // acc:qr is the shifting product register; qr's LSB selects the next partial product
    assign msum = {1'b0, acc} + (qr[0] ? {1'b0, mc} : '0);
    assign prod = neg_lo ? -{acc, qr} : {acc, qr};
`ifdef ALU_DIVIDE_EN
    logic [WIDTH:0] dsh;
    logic [WIDTH-1:0] ddif;
    logic dge, op_div, neg_hi, div0;
    // acc is the partial remainder, qr shifts dividend bits out and quotient bits in
    assign dsh = {acc, qr[WIDTH-1]};
    assign dge = dsh >= {1'b0, mc};
    assign ddif = dsh[WIDTH-1:0] - mc;
    assign fin = !op_div ? prod : {neg_hi ? -acc : acc, div0 ? {WIDTH{1'b1}} : neg_lo ? -qr : qr};
`else
    assign fin = prod;
`endif
    always_comb begin
        res = '0;
        ovf = 1'b0;
        ill = 1'b0;
        start_mul = 1'b0;
        start_div = 1'b0;
        sgn = 1'b0;
        case (alu_op[1] ? func : {4'b1000, alu_op[0], 1'b0})
            6'b100000: begin res = sum; ovf = add_ovf; end
            6'b100001: res = sum;
            6'b100010: begin res = dif; ovf = sub_ovf; end
            6'b100011: res = dif;
            6'b100100: res = src_a & src_b;
            6'b100101: res = src_a | src_b;
            6'b100110: res = src_a ^ src_b;
            6'b100111: res = ~(src_a | src_b);
            6'b101010: res = WIDTH'($signed(src_a) < $signed(src_b));
            6'b101011: res = WIDTH'(src_a < src_b);
            6'b000000: res = src_b << shamt;
            6'b000010: res = src_b >> shamt;
            6'b000011: res = $signed(src_b) >>> shamt;
            6'b010000: res = hi;
            6'b010010: res = lo;
            6'b011000, 6'b011001: begin start_mul = 1'b1; sgn = ~func[0]; end
`ifdef ALU_DIVIDE_EN
            6'b011010, 6'b011011: begin start_div = 1'b1; sgn = ~func[0]; end
`endif
            default: ill = 1'b1;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE: nxt = !accept ? IDLE : start_mul ? MUL :
`ifdef ALU_DIVIDE_EN
                start_div ? DIV :
`endif
                IDLE;
            DONE: nxt = IDLE;
            default: nxt = last ? DONE : state;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
            acc <= '0;
            qr <= '0;
            mc <= '0;
            cnt <= '0;
            neg_lo <= 1'b0;
`ifdef ALU_DIVIDE_EN
            op_div <= 1'b0;
            neg_hi <= 1'b0;
            div0 <= 1'b0;
`endif
            out_valid <= 1'b0;
            out_result <= '0;
            out_zero <= 1'b0;
            out_ovf <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_zero <= 1'b0;
            out_ovf <= 1'b0;
            out_illegal <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (start_mul | start_div) begin
                        acc <= '0;
                        cnt <= '0;
                        mc <= start_div ? abs_b : abs_a;
                        qr <= start_div ? abs_a : abs_b;
                        neg_lo <= sgn & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
`ifdef ALU_DIVIDE_EN
                        op_div <= start_div;
                        neg_hi <= sgn & src_a[WIDTH-1];
                        div0 <= src_b == '0;
`endif
                    end else begin
                        out_valid <= 1'b1;
                        out_result <= res;
                        out_zero <= res == '0;
                        out_ovf <= ovf;
                        out_illegal <= ill;
                    end
                end
                MUL: begin
                    {acc, qr} <= {msum, qr[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                end
`ifdef ALU_DIVIDE_EN
                DIV: begin
                    acc <= dge ? ddif : dsh[WIDTH-1:0];
                    qr <= {qr[WIDTH-2:0], dge};
                    cnt <= cnt + 1'b1;
                end
`endif
                default: begin
                    {hi, lo} <= fin;
                    out_valid <= 1'b1;
                    out_result <= fin[WIDTH-1:0];
                    out_zero <= fin[WIDTH-1:0] == '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench for alu_exec_unit against an arithmetic reference model
module tb_alu_exec_unit;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
    logic in_ready, out_valid, out_zero, out_ovf, out_illegal;
    logic [1:0] alu_op = '0;
    logic [5:0] func = '0;
    logic [4:0] shamt = '0;
    logic [31:0] src_a = '0, src_b = '0, out_result;
    typedef struct packed {logic [31:0] r; logic z, o, i;} exp_t;
    exp_t q[$];
    int total = 0, bad = 0;
    logic [31:0] mhi = '0, mlo = '0;
    logic [5:0] funcs[19] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b,
                              6'h00, 6'h02, 6'h03, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1a, 6'h1b};

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
        .func(func), .shamt(shamt), .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
        .out_result(out_result), .out_zero(out_zero), .out_ovf(out_ovf), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [1:0] op, input logic [5:0] f, input logic [4:0] sh,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint sa, sb, s;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e = '0;
        case (op[1] ? f : (op[0] ? 6'h22 : 6'h20))
            6'h20: begin s = sa + sb; e.r = s[31:0]; e.o = s != longint'($signed(s[31:0])); end
            6'h21: e.r = a + b;
            6'h22: begin s = sa - sb; e.r = s[31:0]; e.o = s != longint'($signed(s[31:0])); end
            6'h23: e.r = a - b;
            6'h24: e.r = a & b;
            6'h25: e.r = a | b;
            6'h26: e.r = a ^ b;
            6'h27: e.r = ~(a | b);
            6'h2a: e.r = 32'(sa < sb);
            6'h2b: e.r = 32'(a < b);
            6'h00: e.r = b << sh;
            6'h02: e.r = b >> sh;
            6'h03: begin s = sb >>> sh; e.r = s[31:0]; end
            6'h10: e.r = mhi;
            6'h12: e.r = mlo;
            6'h18: begin p = 64'(sa * sb); {mhi, mlo} = p; e.r = mlo; end
            6'h19: begin p = {32'b0, a} * {32'b0, b}; {mhi, mlo} = p; e.r = mlo; end
`ifdef ALU_DIVIDE_EN
            6'h1a: begin
                if (b == 0) {mhi, mlo} = {a, 32'hFFFFFFFF};
                else begin s = sa / sb; mlo = s[31:0]; s = sa % sb; mhi = s[31:0]; end
                e.r = mlo;
            end
            6'h1b: begin
                if (b == 0) {mhi, mlo} = {a, 32'hFFFFFFFF};
                else begin mlo = a / b; mhi = a % b; end
                e.r = mlo;
            end
`endif
            default: e.i = 1'b1;
        endcase
        e.z = e.r == 0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, want);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) chk("issue_ready_timeout", 0, 1);
        alu_op = op;
        func = f;
        shamt = sh;
        src_a = a;
        src_b = b;
        in_valid = 1'b1;
        q.push_back(model(op, f, sh, a, b));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", q.size(), 0);
        q.delete();
    endtask

    function automatic logic [31:0] rv();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            total++;
            if (out_valid) begin
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_out_valid got r=%h", out_result);
                end else begin
                    e = q.pop_front();
                    if ({out_result, out_zero, out_ovf, out_illegal} !== e)
                        begin
                            bad++;
                            $display("FAIL result got r=%h z=%b o=%b i=%b want r=%h z=%b o=%b i=%b",
                                     out_result, out_zero, out_ovf, out_illegal, e.r, e.z, e.o, e.i);
                        end
                end
            end else if (out_zero | out_ovf) begin
                bad++;
                $display("FAIL flags_without_valid got z=%b o=%b want 0 0", out_zero, out_ovf);
            end
        end
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL global_timeout got=running want=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int n;
        logic [1:0] op;
        logic [5:0] f;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_flags", {out_zero, out_ovf, out_illegal}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        issue(2'b10, 6'h20, 0, 7, 5);
        issue(2'b10, 6'h20, 0, 32'h7FFFFFFF, 1);
        issue(2'b10, 6'h21, 0, 32'h7FFFFFFF, 1);
        issue(2'b00, 6'h3f, 0, 32'h80000000, 32'h80000000);
        issue(2'b01, 6'h00, 0, 32'h80000000, 1);
        issue(2'b01, 6'h00, 0, 9, 9);
        issue(2'b10, 6'h03, 4, 0, 32'h80000000);
        issue(2'b10, 6'h2b, 0, 1, 32'hFFFFFFFF);
        issue(2'b10, 6'h2a, 0, 1, 32'hFFFFFFFF);
        issue(2'b10, 6'h27, 0, 0, 0);
        issue(2'b10, 6'h3f, 0, 3, 4);
        drain();
        issue(2'b10, 6'h18, 0, -32'sd3, 5);
        in_valid = 1'b1;
        alu_op = 2'b10;
        func = 6'h20;
        n = 0;
        while (!in_ready && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("mult_busy_cycles", n, 33);
        chk("mult_valid_latency", out_valid, 1);
        drain();
        issue(2'b10, 6'h12, 0, 0, 0);
        issue(2'b10, 6'h10, 0, 0, 0);
        issue(2'b10, 6'h1a, 0, -32'sd7, 2);
        issue(2'b10, 6'h10, 0, 0, 0);
        issue(2'b10, 6'h12, 0, 0, 0);
        issue(2'b10, 6'h1b, 0, 7, 0);
        issue(2'b10, 6'h10, 0, 0, 0);
        issue(2'b10, 6'h12, 0, 0, 0);
        issue(2'b10, 6'h1a, 0, 32'h80000000, 32'hFFFFFFFF);
        issue(2'b10, 6'h10, 0, 0, 0);
        drain();
        issue(2'b10, 6'h19, 0, 32'hFFFFFFFF, 2);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midop_rst_valid", out_valid, 0);
        chk("midop_rst_result", out_result, 0);
        chk("midop_rst_ready", in_ready, 1);
        q.delete();
        mhi = '0;
        mlo = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        issue(2'b10, 6'h10, 0, 0, 0);
        issue(2'b10, 6'h12, 0, 0, 0);
        drain();
        for (int i = 0; i < 300; i++) begin
            op = 2'($urandom_range(0, 3));
            f = ($urandom_range(0, 9) == 0) ? 6'($urandom()) : funcs[$urandom_range(0, 18)];
            issue(op, f, 5'($urandom()), rv(), rv());
        end
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
